// File: rtl/sel_n_pipe.sv
// sel_n_pipe: lane selector with a one-cycle registered output and a skid slot so in_ready has no path from out_ready.
module sel_n_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_MODE = 0,
  localparam int SELW = SEL_MODE != 0 ? NUM_IN : ($clog2(NUM_IN) > 1 ? $clog2(NUM_IN) : 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SELW-1:0]         sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);
  typedef enum logic [1:0] {EMPTY, MAIN, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] main_q, main_d, skid_q, skid_d;
  logic [WIDTH-1:0] res_data;
  logic res_err, in_ready_q, in_fire, out_fire;
  if (SEL_MODE != 0) begin : g_oh
    always_comb begin
      res_data = '0;
      for (int k = 0; k < NUM_IN; k++)
        if (sel[k]) res_data = res_data | in_data[k*WIDTH +: WIDTH];
    end
    assign res_err = $countones(sel) != 1;
  end else begin : g_bin
    always_comb begin
      res_data = '0;
      for (int k = 0; k < NUM_IN; k++)
        if (int'(sel) == k) res_data = in_data[k*WIDTH +: WIDTH];
    end
    assign res_err = int'(sel) >= NUM_IN;
  end
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q[WIDTH-1:0] : '0;
  assign out_err   = out_valid & main_q[WIDTH];
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = MAIN;
        main_d = {res_err, res_data};
      end
      MAIN: if (in_fire && out_fire) main_d = {res_err, res_data};
      else if (in_fire) begin
        state_d = FULL;
        skid_d = {res_err, res_data};
      end else if (out_fire) state_d = EMPTY;
      FULL: if (out_fire) begin
        state_d = MAIN;
        main_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      in_ready_q <= state_d != FULL;
    end
  end
endmodule

// File: tb/tb_sel_n_pipe.sv
// tb_sel_n_pipe: three selector variants (binary/4, binary/3, one-hot/4) run in lockstep against a queue-based reference.
module tb_sel_n_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] sel_a = 0, sel_b = 0;
  logic [3:0] sel_c = 0;
  logic [127:0] in_data = 0;
  logic ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, er_a, er_b, er_c;
  logic [31:0] od_a, od_b, od_c;
  typedef struct packed {
    logic [31:0] da, db, dc;
    logic ea, eb, ec;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit just_rst = 0;

  always #5 clk = ~clk;

  sel_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .sel(sel_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_err(er_a));
  sel_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .sel(sel_b), .in_data(in_data[95:0]),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_err(er_b));
  sel_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .sel(sel_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_err(er_c));

  function automatic logic [32:0] ref_bin(int n, int s, logic [127:0] d);
    return s < n ? {1'b0, d[s*32 +: 32]} : {1'b1, 32'd0};
  endfunction

  function automatic logic [32:0] ref_oh(logic [3:0] s, logic [127:0] d);
    int cnt = 0;
    logic [31:0] acc = 0;
    for (int k = 0; k < 4; k++) if (s[k]) begin
      cnt++;
      acc |= d[k*32 +: 32];
    end
    return {cnt != 1, acc};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: model occupancy is q.size(), since pops here precede the next edge's output transfer.
  initial begin
    logic [31:0] hold_d;
    logic hold_e;
    bit hold_v = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) hold_v = 0;
      else begin
        chk("in_ready_a", 32'(ir_a), just_rst ? 0 : 32'(q.size() < 2));
        chk("in_ready_b", 32'(ir_b), just_rst ? 0 : 32'(q.size() < 2));
        chk("in_ready_c", 32'(ir_c), just_rst ? 0 : 32'(q.size() < 2));
        just_rst = 0;
        chk("out_valid_a", 32'(ov_a), 32'(q.size() > 0));
        chk("out_valid_b", 32'(ov_b), 32'(q.size() > 0));
        chk("out_valid_c", 32'(ov_c), 32'(q.size() > 0));
        if (hold_v) begin
          chk("hold_data", od_a, hold_d);
          chk("hold_err", 32'(er_a), 32'(hold_e));
        end
        if (ov_a && q.size() > 0) begin
          e = q[0];
          chk("data_a", od_a, e.da);
          chk("err_a", 32'(er_a), 32'(e.ea));
          chk("data_b", od_b, e.db);
          chk("err_b", 32'(er_b), 32'(e.eb));
          chk("data_c", od_c, e.dc);
          chk("err_c", 32'(er_c), 32'(e.ec));
        end else if (!ov_a) begin
          chk("idle_data_a", od_a, 0);
          chk("idle_err_a", 32'(er_a), 0);
          chk("idle_data_c", od_c, 0);
          chk("idle_err_c", 32'(er_c), 0);
        end
        hold_v = ov_a && !out_ready;
        hold_d = od_a;
        hold_e = er_a;
        if (ov_a && out_ready && q.size() > 0) void'(q.pop_front());
      end
    end
  end

  task automatic cyc(bit r, bit iv, bit ordy, logic [1:0] sa, logic [1:0] sb, logic [3:0] sc, logic [127:0] d);
    logic [32:0] ra, rb, rc;
    @(posedge clk);
    #1;
    rst = r;
    in_valid = iv;
    out_ready = ordy;
    sel_a = sa;
    sel_b = sb;
    sel_c = sc;
    in_data = d;
    @(negedge clk);
    #1;
    if (rst) begin
      q.delete();
      just_rst = 1;
    end else if (in_valid && ir_a) begin
      ra = ref_bin(4, int'(sa), d);
      rb = ref_bin(3, int'(sb), d);
      rc = ref_oh(sc, d);
      q.push_back('{ra[31:0], rb[31:0], rc[31:0], ra[32], rb[32], rc[32]});
    end
  endtask

  function automatic logic [127:0] rd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] l1 = {32'd44, 32'd33, 32'd22, 32'd11};
    logic [127:0] l2 = {32'd8, 32'd4, 32'd2, 32'd1};
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 2, 4'b0100, l1);
    cyc(0, 0, 1, 0, 0, 0, l1);
    cyc(0, 1, 1, 1, 3, 4'b0101, l2);
    cyc(0, 1, 1, 3, 3, 4'b0000, l2);
    cyc(0, 1, 1, 0, 1, 4'b1000, l2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 4'b0010, rd());
    cyc(0, 1, 0, 2, 2, 4'b0100, rd());
    cyc(0, 1, 0, 3, 0, 4'b1000, rd());
    cyc(0, 1, 0, 0, 0, 4'b0001, rd());
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 4'b0010, rd());
    cyc(0, 1, 0, 2, 2, 4'b0100, rd());
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 2, 4'b1000, rd());
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (100) cyc(0, 1, 1, 2'($urandom), 2'($urandom), 4'($urandom), rd());
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 499) == 0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), rd());
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
    chk("drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sel_n_pipe.md
SEL_N_PIPE -- requirements
Module: sel_n_pipe

Interface
REQ-001 Parameter WIDTH, default 32 (`WORD): data width of every input and output lane.
REQ-002 Parameter NUM_IN, default 4, legal range 2..16: number of selectable input lanes.
REQ-003 Parameter SEL_MODE, default 0: 0 = binary select, 1 = one-hot select.
REQ-004 Derived SELW SHALL be max(1, clog2(NUM_IN)) when SEL_MODE=0, and NUM_IN when SEL_MODE=1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream offers sel and in_data this cycle.
REQ-008 in_ready  output  1  block accepts the offer this cycle.
REQ-009 sel  input  SELW  lane select, binary or one-hot per SEL_MODE.
REQ-010 in_data  input  NUM_IN*WIDTH  flattened lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  output  1  out_data and out_err hold a selected result.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out_data  output  WIDTH  selected lane value.
REQ-014 out_err  output  1  select was illegal for the item now presented.

Function
REQ-015 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-016 Binary mode: the result SHALL be lane sel; sel>=NUM_IN SHALL give data 0 and err=1.
REQ-017 One-hot mode: the result SHALL be the bitwise OR of all lanes whose sel bit is 1; err SHALL be 1 when sel has zero set bits or more than one set bit, so sel=0 gives data 0 and err=1.
REQ-018 Data and err SHALL be computed at input acceptance and stored together; later changes on sel or in_data SHALL NOT affect a stored item.
REQ-019 Storage SHALL be a main register driving the outputs plus one skid register; states are EMPTY (0 items), MAIN (1 item), FULL (2 items).
REQ-020 in_ready SHALL be 1 in EMPTY and MAIN and 0 in FULL; in_ready SHALL be a register output with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in MAIN and FULL and 0 in EMPTY.
REQ-022 Latency SHALL be one cycle: an item accepted at edge N appears on out_data/out_valid after edge N when the main register is free.
REQ-023 EMPTY: input transfer -> MAIN, with the item loaded into the main register.
REQ-024 MAIN: input only -> FULL, with the item loaded into skid; output only -> EMPTY; input and output on the same cycle -> MAIN, with the new item loaded into the main register.
REQ-025 FULL: output transfer -> MAIN, with skid moved into the main register; there is no input transfer, since in_ready=0.
REQ-026 Order SHALL be strict FIFO, with no loss and no duplication of items.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable.
REQ-028 When out_valid=0, out_data SHALL be 0 and out_err SHALL be 0.

Reset
REQ-029 On a clock edge with rst=1, the state SHALL go to EMPTY, and out_valid, out_data, out_err and both stored items SHALL clear to 0.
REQ-030 On that same edge, in_ready SHALL be 0; it SHALL be 1 on the first edge with rst=0.
REQ-031 rst asserted mid-operation, including in FULL, SHALL discard all items; no transfer SHALL be counted on a reset cycle.

Verification
REQ-032 Binary mode, NUM_IN=4, lanes={11,22,33,44}, sel=2, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=33, out_err=0.
REQ-033 Binary mode, NUM_IN=3, sel=3 -> out_data=0 and out_err=1 on the item; One-hot mode, sel=4'b0101, lanes={1,2,4,8} -> out_data=5 and out_err=1; sel=4'b0000 -> out_data=0 and out_err=1.
REQ-034 Backpressure: out_ready=0, push A then B -> in_ready=0 after B is accepted and out_data=A is held; raise out_ready -> A then B appear on consecutive cycles, and in_ready returns to 1 after A leaves.
REQ-035 Streaming: in_valid=1 and out_ready=1 continuously for 100 items -> 1 item per cycle, in_ready never 0, output sequence equals input sequence.
REQ-036 Reset in FULL: two items held and rst pulsed one cycle -> out_valid=0 and out_data=0; the next accepted item emerges alone with correct data.
REQ-037 Random in_valid/out_ready at 50% for 10k cycles against a reference FIFO model -> zero mismatches, and out_data/out_err stable on every cycle with out_valid=1 and out_ready=0.
